multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS control unit.
- A Moore/Mealy FSM sequences fetch, decode, execute, memory and writeback over several clocks. It drives the shared-datapath muxes and enables, and handshakes with a single unified memory via mem_ready.
- The memory-wait timeout is parametrised, the ALU-op width is parametrised, and addi and slt are supported.
- Sits between the instruction register (supplies opcode/funct) and the datapath.

Parameters:
- ALUOP_W, 3: width of alu_op; must be >=3; codes are zero-extended.
- MAX_WAIT, 15: maximum cycles to wait for mem_ready in a memory state before timeout; 0 disables the timeout.
- STATE_W, 4: width of the state register; must hold all states.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  0 PC address, 1 ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback from MDR
- reg_dst  out  1  1 rd, 0 rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  ALUOP_W  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal  out  1  one-cycle pulse: unsupported opcode/funct
- mem_err  out  1  one-cycle pulse: memory timeout
- instr_done  out  1  one-cycle pulse in an instruction's final cycle

Behaviour:
- Reset (async, rst_n=0):
  - State is RST; wait counter is 0.
  - All outputs are 0, including alu_op.
  - RST always goes to FETCH on the next clock.
  - Reset mid-instruction abandons it immediately.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE on mem_ready.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=add (branch target).
  - Next state by opcode:
    - 100011 or 101011 goes to MEMADR.
    - 000000 with funct in {100000, 100010, 100100, 100101, 101010} goes to EXEC.
    - 000100 goes to BEQ.
    - 001000 goes to ADDIEX.
    - Anything else raises illegal=1 this cycle and goes to FETCH.
- MEMADR: drives alu_src_a=1, alu_src_b=10, add. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: drives mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: drives reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
- MEMWR:
  - Drives mem_write=1, i_or_d=1; waits for mem_ready.
  - instr_done equals mem_ready; goes to FETCH on mem_ready.
- EXEC:
  - Drives alu_src_a=1, alu_src_b=00.
  - alu_op by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Goes to RWB.
- RWB: drives reg_dst=1, reg_write=1, instr_done=1. Goes to FETCH.
- BEQ: drives alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- ADDIEX: drives alu_src_a=1, alu_src_b=10, add. Goes to ADDIWB.
- ADDIWB: drives reg_dst=0, reg_write=1, instr_done=1. Goes to FETCH.
- Wait counter (FETCH, MEMRD, MEMWR):
  - Clears on entering the state and on mem_ready.
  - Increments each cycle that mem_ready=0.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with mem_ready still 0: mem_err=1 for that cycle, the access is dropped (no ir_write/pc_write/reg_write), and the state goes to FETCH.
  - A timeout in FETCH re-fetches the same PC.
  - mem_ready in the same cycle as reaching MAX_WAIT counts as success, with no error.
- mem_ready outside the memory states is ignored.
- illegal and mem_err are never asserted together.
- Latency with zero-wait memory:
  - R-type, addi and lw: 4, 4 and 5 cycles respectively.
  - sw: 4 cycles.
  - beq: 3 cycles.

Optional Feature:
- Macro MC_JUMP_EN.
- Defined:
  - Opcode 000010 in DECODE goes to JMP.
  - JMP drives pc_write=1, pc_source=10, instr_done=1, then goes to FETCH (3 cycles total).
- Undefined: opcode 000010 is illegal (illegal pulse in DECODE, return to FETCH), and pc_source never equals 10.

Test Plan:
- Reset release, mem_ready=1, R-type add (op 000000, funct 100000) -> FETCH/DECODE/EXEC/RWB; EXEC alu_op=010; RWB reg_write=1, reg_dst=1, instr_done=1; back in FETCH on cycle 5.
- lw (100011), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1, i_or_d=1; MEMWB mem_to_reg=1, reg_write=1; no mem_err.
- sw with MAX_WAIT=15, mem_ready stuck 0 -> mem_err single pulse after 15 wait cycles in MEMWR; mem_write never followed by instr_done; next state FETCH.
- beq (000100) -> BEQ cycle: pc_write_cond=1, pc_source=01, alu_op=110; slt funct 101010 -> EXEC alu_op=111.
- opcode 111111, then funct 000111 with opcode 0 -> illegal pulse in DECODE each time, no reg_write, FETCH next cycle.
- rst_n dropped during MEMWR and during EXEC -> all outputs 0 asynchronously; after release RST then FETCH; j (000010) -> pc_source=10 with MC_JUMP_EN, illegal pulse without.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath/IR (slave).
interface multicycle_controller_if #(
  parameter int unsigned ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_source;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               illegal;
  logic               mem_err;
  logic               instr_done;

  modport master (
    input  opcode, funct, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal, mem_err,
           instr_done
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal, mem_err,
           instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory-wait timeout; define MC_JUMP_EN to add the j instruction.
module multicycle_controller #(
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned STATE_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  localparam int unsigned CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(3'b111);

  typedef enum logic [STATE_W-1:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StRwb, StBeq, StAddiEx, StAddiWb, StJmp
  } state_e;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
  } ctl_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  ctl_t            ctl_q;
  logic            mem_st, timeout, illegal_d;

  function automatic logic r_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // State-only control levels; registered against the state being entered.
  function automatic ctl_t moore_ctl(input state_e st, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (st)
      StFetch:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = AluAdd; end
      StDecode: begin c.alu_src_b = 2'b11; c.alu_op = AluAdd; end
      StMemAdr, StAddiEx: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = AluAdd;
      end
      StMemRd:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      StMemWr:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      StMemWb:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      StExec: begin
        c.alu_src_a = 1'b1;
        case (fn)
          6'b100000: c.alu_op = AluAdd;
          6'b100010: c.alu_op = AluSub;
          6'b100100: c.alu_op = AluAnd;
          6'b100101: c.alu_op = AluOr;
          6'b101010: c.alu_op = AluSlt;
          default:   c.alu_op = '0;
        endcase
      end
      StRwb:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      StBeq: begin
        c.alu_src_a = 1'b1; c.alu_op = AluSub; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
      end
      StAddiWb: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
`ifdef MC_JUMP_EN
      StJmp:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; end
`endif
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = 1'b0;
    timeout   = 1'b0;
    mem_st    = state_q inside {StFetch, StMemRd, StMemWr};
    // Ready on the cycle the counter hits MAX_WAIT still wins over the timeout.
    if (mem_st && !bus.mem_ready) begin
      if (MAX_WAIT != 0 && cnt_q == CntW'(MAX_WAIT)) timeout = 1'b1;
      else                                           cnt_d   = cnt_q + CntW'(1);
    end
    case (state_q)
      StRst:   state_d = StFetch;
      StFetch: if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          6'b100011, 6'b101011: state_d = StMemAdr;
          6'b000000: begin
            if (r_legal(bus.funct)) state_d = StExec;
            else begin state_d = StFetch; illegal_d = 1'b1; end
          end
          6'b000100: state_d = StBeq;
          6'b001000: state_d = StAddiEx;
`ifdef MC_JUMP_EN
          6'b000010: state_d = StJmp;
`endif
          default: begin state_d = StFetch; illegal_d = 1'b1; end
        endcase
      end
      StMemAdr: state_d = (bus.opcode == 6'b100011) ? StMemRd : StMemWr;
      StMemRd: begin
        if (bus.mem_ready) state_d = StMemWb;
        else if (timeout)  state_d = StFetch;
      end
      StMemWr:  if (bus.mem_ready || timeout) state_d = StFetch;
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRst;
      cnt_q   <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= moore_ctl(state_d, bus.funct);
    end
  end

  assign bus.pc_write      = ctl_q.pc_write | (state_q == StFetch && bus.mem_ready);
  assign bus.ir_write      = (state_q == StFetch) && bus.mem_ready;
  assign bus.instr_done    = ctl_q.instr_done | (state_q == StMemWr && bus.mem_ready);
  assign bus.illegal       = illegal_d;
  assign bus.mem_err       = timeout;
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.pc_source     = ctl_q.pc_source;
  assign bus.i_or_d        = ctl_q.i_or_d;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.mem_to_reg    = ctl_q.mem_to_reg;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.alu_op        = ctl_q.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: instruction-level model expands each instruction into
// per-cycle expected control vectors; one negedge process compares them against the DUT.
module tb_multicycle_controller;

  localparam int unsigned MaxWait = 15;
  localparam bit B0 = 1'b0;
  localparam bit B1 = 1'b1;
  localparam logic [2:0] AAdd = 3'b010, ASub = 3'b110, AAnd = 3'b000, AOr = 3'b001,
                         ASlt = 3'b111;
  localparam logic [5:0] OpR = 6'h00, OpLw = 6'h23, OpSw = 6'h2b, OpBeq = 6'h04,
                         OpAddi = 6'h08, OpJ = 6'h02;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if #(.ALUOP_W(3)) bus ();

  multicycle_controller #(
    .ALUOP_W (3),
    .MAX_WAIT(MaxWait),
    .STATE_W (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    bit          model;
    logic [19:0] exp;
    int          act_n;
    int          exp_n;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;
  int   stop_lim = -1;

  logic [19:0] dut_vec;
  assign dut_vec = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                    bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal, bus.mem_err,
                    bus.instr_done};

  always @(negedge clk) begin : compare
    rec_t r;
    while (exp_q.size() > 0 && exp_q[0].model) begin
      r = exp_q.pop_front();
      checks++;
      if (r.act_n != r.exp_n) begin
        failures++;
        $display("FAIL %s: got %0d want %0d", r.name, r.act_n, r.exp_n);
      end
    end
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      checks++;
      if (dut_vec !== r.exp) begin
        failures++;
        $display("FAIL %s @%0t: got %05h want %05h", r.name, $time, dut_vec, r.exp);
      end
    end
  end

  function automatic logic [19:0] mk(input bit pcw, input bit pcwc, input logic [1:0] pcs,
                                     input bit iord, input bit mr, input bit mw, input bit irw,
                                     input bit m2r, input bit rd, input bit rw, input bit asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input bit ill, input bit merr, input bit done);
    return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ill, merr, done};
  endfunction

  function automatic logic [2:0] rop(input logic [5:0] fn);
    case (fn)
      6'h20:   return AAdd;
      6'h22:   return ASub;
      6'h24:   return AAnd;
      6'h25:   return AOr;
      default: return ASlt;
    endcase
  endfunction

  task automatic cyc(input string nm, input logic rdy, input logic [19:0] e);
    rec_t r;
    if (stop_lim >= 0 && ncyc >= stop_lim) return;
    r.name = nm; r.model = 1'b0; r.exp = e; r.act_n = 0; r.exp_n = 0;
    bus.mem_ready = rdy;
    exp_q.push_back(r);
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic lat(input string nm, input int act, input int want);
    rec_t r;
    r.name = nm; r.model = 1'b1; r.exp = '0; r.act_n = act; r.exp_n = want;
    exp_q.push_back(r);
  endtask

  // Any wait longer than MaxWait ends in a timeout and a fresh fetch attempt.
  task automatic fetch_phase(input int fw);
    int rem;
    rem = fw;
    while (rem > int'(MaxWait)) begin
      for (int i = 0; i <= int'(MaxWait); i++)
        cyc("fetch_to", 1'b0, mk(B0, B0, 2'b00, B0, B1, B0, B0, B0, B0, B0, B0, 2'b01, AAdd,
                                 B0, bit'(i == int'(MaxWait)), B0));
      rem -= int'(MaxWait) + 1;
    end
    for (int i = 0; i < rem; i++)
      cyc("fetch_wait", 1'b0, mk(B0, B0, 2'b00, B0, B1, B0, B0, B0, B0, B0, B0, 2'b01, AAdd,
                                 B0, B0, B0));
    cyc("fetch", 1'b1, mk(B1, B0, 2'b00, B0, B1, B0, B1, B0, B0, B0, B0, 2'b01, AAdd,
                          B0, B0, B0));
  endtask

  task automatic mem_phase(input bit wr, input int mw, output bit ok);
    ok = (mw <= int'(MaxWait));
    if (!ok) begin
      for (int i = 0; i <= int'(MaxWait); i++)
        cyc(wr ? "memwr_to" : "memrd_to", 1'b0,
            mk(B0, B0, 2'b00, B1, !wr, wr, B0, B0, B0, B0, B0, 2'b00, 3'b000, B0,
               bit'(i == int'(MaxWait)), B0));
    end else begin
      for (int i = 0; i < mw; i++)
        cyc(wr ? "memwr_wait" : "memrd_wait", 1'b0,
            mk(B0, B0, 2'b00, B1, !wr, wr, B0, B0, B0, B0, B0, 2'b00, 3'b000, B0, B0, B0));
      cyc(wr ? "memwr" : "memrd", 1'b1,
          mk(B0, B0, 2'b00, B1, !wr, wr, B0, B0, B0, B0, B0, 2'b00, 3'b000, B0, B0, wr));
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int stop, output int n);
    bit r_ok, j_ok, ok, ill;
    bus.opcode = op;
    bus.funct  = fn;
    ncyc       = 0;
    stop_lim   = stop;
    r_ok = (op == OpR) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
`ifdef MC_JUMP_EN
    j_ok = (op == OpJ);
`else
    j_ok = 1'b0;
`endif
    ill = !(r_ok || j_ok || op inside {OpLw, OpSw, OpBeq, OpAddi});
    fetch_phase(fw);
    cyc("decode", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B0, B0, B0, 2'b11, AAdd,
                           ill, B0, B0));
    if (op == OpLw || op == OpSw) begin
      cyc("memadr", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B0, B0, B1, 2'b10, AAdd,
                             B0, B0, B0));
      mem_phase(op == OpSw, mw, ok);
      if (op == OpLw && ok)
        cyc("memwb", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B1, B0, B1, B0, 2'b00, 3'b000,
                              B0, B0, B1));
    end else if (r_ok) begin
      cyc("exec", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B0, B0, B1, 2'b00, rop(fn),
                           B0, B0, B0));
      cyc("rwb", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B1, B1, B0, 2'b00, 3'b000,
                          B0, B0, B1));
    end else if (op == OpBeq) begin
      cyc("beq", 1'b1, mk(B0, B1, 2'b01, B0, B0, B0, B0, B0, B0, B0, B1, 2'b00, ASub,
                          B0, B0, B1));
    end else if (op == OpAddi) begin
      cyc("addiex", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B0, B0, B1, 2'b10, AAdd,
                             B0, B0, B0));
      cyc("addiwb", 1'b1, mk(B0, B0, 2'b00, B0, B0, B0, B0, B0, B0, B1, B0, 2'b00, 3'b000,
                             B0, B0, B1));
    end else if (j_ok) begin
      cyc("jmp", 1'b1, mk(B1, B0, 2'b10, B0, B0, B0, B0, B0, B0, B0, B0, 2'b00, 3'b000,
                          B0, B0, B1));
    end
    n = ncyc;
  endtask

  // Reset asserted mid-cycle: outputs must drop before any clock edge, then one RST cycle.
  task automatic reset_pulse(input string nm);
    stop_lim      = -1;
    bus.mem_ready = 1'b0;
    rst_n         = 1'b0;
    cyc(nm, 1'b0, 20'h0);
    rst_n = 1'b1;
    cyc("rst_state", 1'b0, 20'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    @(posedge clk);
    #1;
    reset_pulse("rst_init");

    run_instr(OpR, 6'h20, 0, 0, -1, n);    lat("lat_add", n, 4);
    run_instr(OpAddi, 6'h3f, 0, 0, -1, n); lat("lat_addi", n, 4);
    run_instr(OpLw, 6'h00, 0, 0, -1, n);   lat("lat_lw", n, 5);
    run_instr(OpSw, 6'h00, 0, 0, -1, n);   lat("lat_sw", n, 4);
    run_instr(OpBeq, 6'h00, 0, 0, -1, n);  lat("lat_beq", n, 3);
    run_instr(OpR, 6'h2a, 0, 0, -1, n);    lat("lat_slt", n, 4);
    run_instr(OpR, 6'h22, 2, 0, -1, n);    lat("lat_sub_fw2", n, 6);
    run_instr(OpR, 6'h24, 1, 0, -1, n);
    run_instr(OpR, 6'h25, 0, 0, -1, n);
    run_instr(OpLw, 6'h00, 0, 3, -1, n);   lat("lat_lw_w3", n, 8);
    run_instr(OpLw, 6'h00, 0, 15, -1, n);  lat("lat_lw_w15", n, 20);
    run_instr(OpLw, 6'h00, 0, 16, -1, n);  lat("lat_lw_to", n, 19);
    run_instr(OpSw, 6'h00, 0, 40, -1, n);  lat("lat_sw_to", n, 19);
    run_instr(6'h3f, 6'h00, 0, 0, -1, n);  lat("lat_ill_op", n, 2);
    run_instr(OpR, 6'h07, 0, 0, -1, n);    lat("lat_ill_fn", n, 2);
    run_instr(OpR, 6'h20, 20, 0, -1, n);   lat("lat_fetch_to", n, 24);
    run_instr(OpJ, 6'h00, 0, 0, -1, n);
`ifdef MC_JUMP_EN
    lat("lat_j", n, 3);
`else
    lat("lat_j", n, 2);
`endif

    run_instr(OpSw, 6'h00, 0, 5, 3, n);
    reset_pulse("rst_in_memwr");
    run_instr(OpR, 6'h22, 0, 0, 2, n);
    reset_pulse("rst_in_exec");
    run_instr(OpR, 6'h20, 0, 0, -1, n);    lat("lat_add_post_rst", n, 4);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
